// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_pkg
// Purpose  : Shared definitions for the ALU arbiter slice: ALU opcode
//            encodings, data width and the legal-opcode helper.
// Ports    : n/a (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_arbiter_pkg;

  localparam int DATAW = 32;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;
  localparam logic [2:0] OP_SRA = 3'b101;

  // Codes 110 and 111 are reserved and treated as illegal.
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_SRA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Purpose  : 32-bit combinational ALU (add, sub, and, or, srl, sra).
// Ports    : a, b  - operands
//            op    - ALU opcode
//            y     - result (zero for reserved opcodes)
// Revision : 1.0 - initial release
// ============================================================================
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [DATAW-1:0] a,
  input  logic [DATAW-1:0] b,
  input  logic [2:0]       op,
  output logic [DATAW-1:0] y
);

  // Shift amounts use the full B operand; anything >= 32 saturates.
  logic shift_big;
  assign shift_big = |b[DATAW-1:5];

  always_comb begin
    y = '0;
    case (op)
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_SRL: y = shift_big ? '0 : (a >> b[4:0]);
      OP_SRA: y = shift_big ? {DATAW{a[DATAW-1]}}
                            : $unsigned($signed(a) >>> b[4:0]);
      default: y = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker. Searches the request vector
//            starting just after last_grant, wrapping modulo NREQ.
// Ports    : req        - request vector
//            last_grant - index granted most recently
//            grant      - one-hot grant (zero when nothing requests)
//            win_idx    - index of the winner (zero when nothing requests)
//            any_valid  - at least one request bit is set
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  win_idx,
  output logic            any_valid
);

  int cand;

  always_comb begin
    grant     = '0;
    win_idx   = '0;
    any_valid = 1'b0;
    cand      = 0;
    // Offset NREQ lands back on last_grant itself, so it is checked last.
    for (int off = 1; off <= NREQ; off++) begin
      cand = (int'(last_grant) + off) % NREQ;
      if (!any_valid && req[cand]) begin
        any_valid   = 1'b1;
        win_idx     = IDW'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one 32-bit ALU between NREQ requesters with round-robin
//            arbitration and a single-entry registered result channel.
// Ports    : clk, reset_n       - clock, async active-low reset
//            req_valid/ready    - per-requester request handshake
//            req_a, req_b       - packed 32-bit operands, slice i per requester
//            req_op             - packed 3-bit opcodes, slice i per requester
//            res_valid/ready    - result handshake
//            res_data, res_id   - result value and issuing requester
//            res_err            - op code was illegal
//            op_count           - accepted-op counter (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*DATAW-1:0] req_a,
  input  logic [NREQ*DATAW-1:0] req_b,
  input  logic [NREQ*3-1:0]     req_op,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATAW-1:0]      res_data,
  output logic [IDW-1:0]        res_id,
  output logic                  res_err,
  output logic [31:0]           op_count
);

  logic [DATAW-1:0] a_arr  [NREQ];
  logic [DATAW-1:0] b_arr  [NREQ];
  logic [2:0]       op_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i]  = req_a[i*DATAW +: DATAW];
    assign b_arr[i]  = req_b[i*DATAW +: DATAW];
    assign op_arr[i] = req_op[i*3 +: 3];
  end

  logic [IDW-1:0]   last_grant;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   win_idx;
  logic             any_valid;
  logic             accept;
  logic             fire;
  logic [DATAW-1:0] sel_a;
  logic [DATAW-1:0] sel_b;
  logic [2:0]       sel_op;
  logic [DATAW-1:0] alu_y;
  logic             sel_legal;
  logic [DATAW-1:0] next_data;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .win_idx    (win_idx),
    .any_valid  (any_valid)
  );

  // The output register can take a new result when empty or draining now.
  assign accept    = !res_valid || res_ready;
  assign fire      = accept && any_valid;
  assign req_ready = accept ? grant : '0;

  assign sel_a  = a_arr[win_idx];
  assign sel_b  = b_arr[win_idx];
  assign sel_op = op_arr[win_idx];

  alu u_alu (
    .a  (sel_a),
    .b  (sel_b),
    .op (sel_op),
    .y  (alu_y)
  );

  // Illegal ops still consume a slot but report zero data with an error flag.
  assign sel_legal = op_is_legal(sel_op);
  assign next_data = sel_legal ? alu_y : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_id     <= '0;
      res_err    <= 1'b0;
      op_count   <= '0;
      last_grant <= IDW'(NREQ - 1);
    end else begin
      if (fire) begin
        res_valid  <= 1'b1;
        res_data   <= next_data;
        res_id     <= win_idx;
        res_err    <= !sel_legal;
        last_grant <= win_idx;
        op_count   <= op_count + 32'd1;
      end else if (res_ready) begin
        // Drain: payload holds, only the valid flag drops.
        res_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter with a result scoreboard.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ*3-1:0] req_op;
  logic              res_valid;
  logic              res_ready;
  logic [31:0]       res_data;
  logic [IDW-1:0]    res_id;
  logic              res_err;
  logic [31:0]       op_count;

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_err   (res_err),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected result packed as {err, id, data}.
  logic [34:0] sb [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_exp(input logic [31:0] data, input int id, input logic err);
    sb.push_back({err, IDW'(id), data});
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_op[i*3 +: 3]  = op;
    req_valid[i]      = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a result is delivered on any edge where valid and ready are both
  // high; sample mid-cycle where inputs and outputs are stable.
  always @(negedge clk) begin
    if (reset_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", {29'd0, res_err, res_id, res_data}, 64'hDEAD);
      end else begin
        logic [34:0] e;
        e = sb.pop_front();
        chk("result", {29'd0, res_err, res_id, res_data}, {29'd0, e});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    res_ready = 1'b1;
    step();
    step();
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data",  64'(res_data),  64'd0);
    chk("rst_res_id_err", {62'd0, res_id} | 64'(res_err), 64'd0);
    chk("rst_op_count",  64'(op_count),  64'd0);
    reset_n = 1'b1;
    step();

    // Round-robin with all four requesters valid: grants 0,1,2,3,0.
    for (int i = 0; i < NREQ; i++) set_req(i, 32'd100 + 32'(i), 32'(i), 3'b000);
    for (int k = 0; k < 5; k++) begin
      int w;
      w = k % NREQ;
      if (k > 0) chk("rr_no_bubble", 64'(res_valid), 64'd1);
      #1;
      chk("rr_ready", 64'(req_ready), 64'(1 << w));
      push_exp(32'd100 + 32'(2 * w), w, 1'b0);
      step();
    end
    req_valid = '0;
    chk("rr_op_count", 64'(op_count), 64'd5);
    step();

    // Single requester 0: 7 + 5.
    set_req(0, 32'd7, 32'd5, 3'b000);
    #1;
    chk("add_ready", 64'(req_ready), 64'b0001);
    push_exp(32'd12, 0, 1'b0);
    step();
    req_valid = '0;
    chk("add_res_valid", 64'(res_valid), 64'd1);
    chk("add_op_count", 64'(op_count), 64'd6);

    // Shifts from requester 2.
    set_req(2, 32'h8000_0000, 32'd4, 3'b101);
    #1;
    chk("sra4_ready", 64'(req_ready), 64'b0100);
    push_exp(32'hF800_0000, 2, 1'b0);
    step();
    set_req(2, 32'h8000_0000, 32'd40, 3'b101);
    #1;
    chk("sra40_ready", 64'(req_ready), 64'b0100);
    push_exp(32'hFFFF_FFFF, 2, 1'b0);
    step();
    set_req(2, 32'h8000_0000, 32'd40, 3'b100);
    push_exp(32'h0000_0000, 2, 1'b0);
    step();
    req_valid = '0;

    // Sub wrap from requester 1, then illegal op from requester 3.
    set_req(1, 32'd0, 32'd1, 3'b001);
    #1;
    chk("sub_ready", 64'(req_ready), 64'b0010);
    push_exp(32'hFFFF_FFFF, 1, 1'b0);
    step();
    req_valid = '0;
    set_req(3, 32'd5, 32'd6, 3'b111);
    #1;
    chk("ill_ready", 64'(req_ready), 64'b1000);
    push_exp(32'd0, 3, 1'b1);
    step();
    req_valid = '0;
    chk("ill_op_count", 64'(op_count), 64'd11);

    // AND / OR from requester 0.
    set_req(0, 32'h0000_F0F0, 32'h0000_FF00, 3'b010);
    push_exp(32'h0000_F000, 0, 1'b0);
    step();
    set_req(0, 32'h0000_F0F0, 32'h0000_FF00, 3'b011);
    push_exp(32'h0000_FFF0, 0, 1'b0);
    step();
    req_valid = '0;
    step();
    chk("drained", 64'(res_valid), 64'd0);

    // Back-pressure: hold a result for three cycles.
    res_ready = 1'b0;
    set_req(1, 32'd1, 32'd1, 3'b000);
    #1;
    chk("bp_first_ready", 64'(req_ready), 64'b0010);
    push_exp(32'd2, 1, 1'b0);
    step();
    set_req(0, 32'd3, 32'd4, 3'b000);
    set_req(1, 32'd10, 32'd20, 3'b000);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready_low", 64'(req_ready), 64'd0);
      chk("bp_hold", {29'd0, res_valid, res_id, res_data}, {29'd0, 1'b1, 2'd1, 32'd2});
      step();
    end
    // Release: drain and grant in one edge; pointer at 1 so requester 0 wins.
    res_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(req_ready), 64'b0001);
    step();
    req_valid = '0;
    res_ready = 1'b0;
    chk("bp_no_bubble", {29'd0, res_valid, res_id, res_data}, {29'd0, 1'b1, 2'd0, 32'd7});
    chk("bp_op_count", 64'(op_count), 64'd15);

    // Asynchronous reset mid-cycle discards the pending result.
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_clear", {29'd0, res_valid, res_id, res_data}, 64'd0);
    chk("arst_op_count", 64'(op_count), 64'd0);
    step();
    #2;
    reset_n   = 1'b1;
    res_ready = 1'b1;
    step();
    set_req(0, 32'd1, 32'd2, 3'b001);
    set_req(2, 32'd9, 32'd1, 3'b000);
    #1;
    chk("post_rst_ready0", 64'(req_ready), 64'b0001);
    push_exp(32'hFFFF_FFFF, 0, 1'b0);
    step();
    #1;
    chk("post_rst_ready2", 64'(req_ready), 64'b0100);
    push_exp(32'd10, 2, 1'b0);
    step();
    req_valid = '0;
    step();
    step();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("final_op_count", 64'(op_count), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 32-bit combinational ALU between NREQ requesters using round-robin arbitration.
- Each requester uses a valid/ready request channel; one registered result channel carries the winner's ID back.
- Sits between the decode/issue units and the ALU instance; it is the only block that drives the ALU inputs.
- Single-entry output register gives one-cycle latency and a throughput of one op per cycle.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester ID; must equal ceil(log2(NREQ)), minimum 1.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  bit i = requester i has an op pending.
- req_ready  out  NREQ  bit i = requester i's op accepted this cycle; one-hot or zero.
- req_a  in  NREQ*32  operand A; slice i = bits [32i+31:32i].
- req_b  in  NREQ*32  operand B, sliced the same way.
- req_op  in  NREQ*3  ALUOp; slice i = bits [3i+2:3i].
- res_valid  out  1  result register holds an undelivered result.
- res_ready  in  1  consumer accepts the result.
- res_data  out  32  ALU result.
- res_id  out  IDW  index of the requester that issued the op.
- res_err  out  1  op code was illegal (110/111).
- op_count  out  32  number of accepted ops; wraps modulo 2^32.

Behaviour:
- Reset (asynchronous assert, synchronous release), all outputs forced low/zero:
  - res_valid=0, res_data=0, res_id=0, res_err=0, op_count=0.
  - Round-robin pointer last_grant=NREQ-1, so requester 0 has top priority after reset.
- ALU opcode set:
  - 000 add, 001 sub, 010 and, 011 or.
  - 100 logical right shift by full B; B>=32 gives 0.
  - 101 arithmetic right shift by full B; B>=32 gives 32 copies of A[31].
  - Add and sub wrap modulo 2^32; no overflow flag.
- accept = !res_valid || res_ready, i.e. the output register is empty or draining this cycle.
- Arbitration (combinational, same cycle):
  - Search req_valid starting at index last_grant+1, wrapping modulo NREQ; the first set bit wins.
  - req_ready[win]=1 only if accept; all other req_ready bits are 0.
  - With no valid request, req_ready=0 and no state changes except the drain below.
- On a clock edge with a grant:
  - res_data takes the ALU output for the winner's A/B/op.
  - res_id takes the winner index; res_valid becomes 1.
  - last_grant takes the winner index; op_count increments by 1.
- Illegal op (110/111): the op is still accepted, counted and takes a grant slot. res_data=0 and res_err=1. For legal ops res_err=0.
- Drain without a new grant (res_valid && res_ready && no winner): res_valid becomes 0; res_data, res_id and res_err hold their values.
- Simultaneous drain and grant: the new result replaces the old one in the same edge, so res_valid stays 1 with no bubble.
- Back-pressure (res_valid && !res_ready): req_ready=0, and the register and pointer hold. Requesters must keep valid and operands stable until ready; the arbiter does not latch operands.
- Fairness: a continuously requesting requester is granted within NREQ accepted ops.
- Reset asserted mid-operation: the pending result is discarded and the pointer returns to NREQ-1.
- Latency: request accepted on edge k gives res_valid=1 visible after edge k.
- Throughput: one op per cycle while res_ready=1.

Decomposition:
- Shared package holds:
  - ALUOp localparams: OP_ADD=3'b000, OP_SUB=3'b001, OP_AND=3'b010, OP_OR=3'b011, OP_SRL=3'b100, OP_SRA=3'b101.
  - A helper for the legal-op check (op <= 3'b101).
- Sub-module rr_pick: combinational round-robin picker. Inputs are the request vector and last_grant; outputs are the one-hot grant, the winner index and an any-valid flag. It is reused by future shared-unit arbiters.
- The existing alu module is instantiated once, fed through a mux selected by the winner index. The illegal-op override is applied after the ALU.

Test Plan:
- Reset, then requester 0 only, A=7, B=5, op=000, res_ready=1 -> req_ready=0001 same cycle; next cycle res_valid=1, res_data=12, res_id=0, res_err=0, op_count=1.
- All four valid every cycle, res_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; res_id follows 0,1,2,3,0 with no bubbles.
- Requester 2 op=101, A=0x80000000, B=4 -> res_data=0xF8000000. Repeat with B=40 -> 0xFFFFFFFF. op=100 with B=40 -> 0.
- Requester 1 op=001, A=0, B=1 -> 0xFFFFFFFF. Requester 3 op=111 -> res_data=0, res_err=1, op_count incremented.
- Result pending and res_ready=0 for 3 cycles with requesters 0/1 valid -> req_ready=0, outputs stable; then res_ready=1 -> drain and a new grant to the next requester in the same edge.
- Assert reset_n=0 between edges while res_valid=1 -> outputs clear immediately; after release the first grant goes to requester 0.
